mem_arbiter_nch: RTL and testbench

//  Parametrised arbiter sharing one multicycle main memory (memory4c-style: pipelined,

---
 rtl/mem_arbiter_nch.sv | 247 ++++++++++++++++++++++++
 tb/tb_mem_arbiter_nch.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_nch.sv
// mem_arbiter_nch: shares one pipelined, fixed-latency main memory between NUM_CH
// cache controllers. One channel owns the memory at a time. A read owner gets a
// BURST_LEN-word line fill. A write owner gets a single-word write-through.
// Arbitration is either fixed priority (lowest index wins) or round-robin.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   ch_req          per-channel request level, held until ch_done
//   ch_wr           per-channel kind: 1 = single-word write, 0 = burst read
//   ch_addr         packed request addresses (ch0 in the LSBs)
//   ch_wdata        packed write data (ch0 in the LSBs)
//   ch_grant        one-hot current owner (zero while idle)
//   ch_rvalid       read word strobe for the owner
//   ch_rdata        returned word, shared by all channels; qualify with ch_rvalid
//   ch_word_idx     burst position of ch_rdata
//   ch_done         single-cycle pulse when the owner's transaction completes
//   mem_*           command and data interface to the memory
//
// The state, owner, latched base address and counters are registers. ch_grant and
// the mem_* command outputs decode those registers directly. ch_rvalid, ch_rdata,
// ch_word_idx and ch_done are not registered: a returned word must reach the
// owner in the same cycle as mem_data_valid.
module mem_arbiter_nch #(
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned BURST_LEN = 8,
    parameter int unsigned ADDR_STEP = 2,
    parameter int unsigned MEM_LAT   = 4,
    parameter int unsigned ARB_MODE  = 0,
    localparam int unsigned IDX_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH-1:0]          ch_req,
    input  logic [NUM_CH-1:0]          ch_wr,
    input  logic [NUM_CH*ADDR_W-1:0]   ch_addr,
    input  logic [NUM_CH*DATA_W-1:0]   ch_wdata,
    output logic [NUM_CH-1:0]          ch_grant,
    output logic [NUM_CH-1:0]          ch_rvalid,
    output logic [DATA_W-1:0]          ch_rdata,
    output logic [IDX_W-1:0]           ch_word_idx,
    output logic [NUM_CH-1:0]          ch_done,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic                       mem_enable,
    output logic                       mem_wr,
    output logic [DATA_W-1:0]          mem_data_in,
    input  logic [DATA_W-1:0]          mem_data_out,
    input  logic                       mem_data_valid
);

    localparam int unsigned PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned OFF_W = $clog2(BURST_LEN * ADDR_STEP);
    localparam logic [ADDR_W-1:0] LINE_MASK = {ADDR_W{1'b1}} << OFF_W;
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(BURST_LEN - 1);

    // Reject parameter sets the burst addressing cannot support.
    if ((BURST_LEN == 0) || ((BURST_LEN & (BURST_LEN - 1)) != 0)) begin : g_chk_burst
        $error("BURST_LEN must be a non-zero power of two");
    end
    if (MEM_LAT < 1) begin : g_chk_lat
        $error("MEM_LAT must be at least 1");
    end
    if (NUM_CH < 1) begin : g_chk_ch
        $error("NUM_CH must be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [PTR_W-1:0]   owner;
    logic [PTR_W-1:0]   rr_ptr;
    logic [ADDR_W-1:0]  base_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [IDX_W-1:0]   issue_cnt;
    logic [IDX_W-1:0]   ret_cnt;

    logic [PTR_W-1:0]   win;
    logic               win_found;
    int unsigned        cand;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;
    logic [PTR_W-1:0]   ptr_nxt;
    logic [NUM_CH-1:0]  owner_oh;

    logic               ret_hit;
    logic               last_ret;
    logic               last_issue;

    // Returns are only meaningful while a read burst is in flight; stale strobes are dropped.
    assign ret_hit    = mem_data_valid && ((state == S_ISSUE) || (state == S_DRAIN));
    assign last_ret   = ret_hit && (ret_cnt == LAST_IDX);
    assign last_issue = (issue_cnt == LAST_IDX);
    assign owner_oh   = NUM_CH'(1) << owner;

    // Winner search starting at rr_ptr. rr_ptr stays at zero in fixed mode.
    always_comb begin
        win       = '0;
        win_found = 1'b0;
        cand      = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = (32'(rr_ptr) + 32'(i)) % NUM_CH;
            if (!win_found && ch_req[PTR_W'(cand)]) begin
                win       = PTR_W'(cand);
                win_found = 1'b1;
            end
        end
    end

    // Select the winner's address and write data from the packed buses.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (PTR_W'(i) == win) begin
                sel_addr  = ch_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = ch_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // The round-robin pointer moves to the channel after the winner, wrapping to ch0.
    always_comb begin
        ptr_nxt = win + 1'b1;
        if (win == PTR_W'(NUM_CH - 1)) begin
            ptr_nxt = '0;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (win_found) begin
                    state_nxt = ch_wr[win] ? S_WRITE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (last_ret) begin
                    state_nxt = S_IDLE;
                end else if (last_issue) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (last_ret) begin
                    state_nxt = S_IDLE;
                end
            end
            S_WRITE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Owner, latched request and burst counters. The owner's live inputs are ignored after the grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner     <= '0;
            rr_ptr    <= '0;
            base_q    <= '0;
            wdata_q   <= '0;
            issue_cnt <= '0;
            ret_cnt   <= '0;
        end else begin
            if (state == S_IDLE) begin
                issue_cnt <= '0;
                ret_cnt   <= '0;
                if (win_found) begin
                    owner   <= win;
                    base_q  <= ch_wr[win] ? sel_addr : (sel_addr & LINE_MASK);
                    wdata_q <= sel_wdata;
                    rr_ptr  <= (ARB_MODE == 1) ? ptr_nxt : '0;
                end
            end
            if ((state == S_ISSUE) && !last_issue) begin
                issue_cnt <= issue_cnt + 1'b1;
            end
            if (ret_hit) begin
                ret_cnt <= last_ret ? '0 : (ret_cnt + 1'b1);
            end
        end
    end

    // Output decode from the state and the burst registers.
    always_comb begin
        ch_grant    = '0;
        ch_rvalid   = '0;
        ch_rdata    = '0;
        ch_word_idx = '0;
        ch_done     = '0;
        mem_addr    = '0;
        mem_enable  = 1'b0;
        mem_wr      = 1'b0;
        mem_data_in = '0;

        if (state != S_IDLE) begin
            ch_grant = owner_oh;
        end

        case (state)
            S_ISSUE: begin
                mem_enable = 1'b1;
                mem_addr   = base_q + ADDR_W'(32'(issue_cnt) * ADDR_STEP);
            end
            S_WRITE: begin
                mem_enable  = 1'b1;
                mem_wr      = 1'b1;
                mem_addr    = base_q;
                mem_data_in = wdata_q;
                ch_done     = owner_oh;
            end
            default: begin
            end
        endcase

        if (ret_hit) begin
            ch_rvalid   = owner_oh;
            ch_rdata    = mem_data_out;
            ch_word_idx = ret_cnt;
            if (last_ret) begin
                ch_done = owner_oh;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter_nch.sv
// Bench for mem_arbiter_nch. Two instances are built: one with fixed priority and one
// with round-robin, each with three channels. Only one instance is active at a time.
// A latency-pipelined memory model serves whichever instance is active. Each batch of
// per-channel transactions is ordered by a service-order model. The model writes the
// expected transactions into a queue, and a monitor checks the observed bus
// cycle-by-cycle against that queue.
module tb_mem_arbiter_nch;

    localparam int NC   = 3;
    localparam int AW   = 16;
    localparam int DW   = 16;
    localparam int BL   = 8;
    localparam int STEP = 2;
    localparam int LAT  = 4;
    localparam int IW   = 3;

    typedef struct {
        int          ch;
        bit          wr;
        logic [15:0] addr;
        logic [15:0] wdata;
    } txn_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              act;
    logic [NC-1:0]     req, wr;
    logic [NC*AW-1:0]  addr;
    logic [NC*DW-1:0]  wdata;
    logic [DW-1:0]     mem_dout;
    logic              mem_dv;

    logic [NC-1:0] f_req, f_grant, f_rvalid, f_done, r_req, r_grant, r_rvalid, r_done;
    logic [DW-1:0] f_rdata, f_din, r_rdata, r_din;
    logic [IW-1:0] f_idx, r_idx;
    logic [AW-1:0] f_maddr, r_maddr;
    logic          f_en, f_wr, r_en, r_wr, f_dv, r_dv;

    logic [NC-1:0] o_grant, o_rvalid, o_done;
    logic [DW-1:0] o_rdata, o_din;
    logic [IW-1:0] o_idx;
    logic [AW-1:0] o_maddr;
    logic          o_en, o_wr;

    assign f_req = act ? '0 : req;
    assign r_req = act ? req : '0;
    assign f_dv  = !act && mem_dv;
    assign r_dv  = act && mem_dv;

    assign o_grant  = act ? r_grant  : f_grant;
    assign o_rvalid = act ? r_rvalid : f_rvalid;
    assign o_done   = act ? r_done   : f_done;
    assign o_rdata  = act ? r_rdata  : f_rdata;
    assign o_din    = act ? r_din    : f_din;
    assign o_idx    = act ? r_idx    : f_idx;
    assign o_maddr  = act ? r_maddr  : f_maddr;
    assign o_en     = act ? r_en     : f_en;
    assign o_wr     = act ? r_wr     : f_wr;

    mem_arbiter_nch #(.NUM_CH(NC), .ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL),
                      .ADDR_STEP(STEP), .MEM_LAT(LAT), .ARB_MODE(0)) dut_fix (
        .clk(clk), .rst(rst), .ch_req(f_req), .ch_wr(wr), .ch_addr(addr), .ch_wdata(wdata),
        .ch_grant(f_grant), .ch_rvalid(f_rvalid), .ch_rdata(f_rdata), .ch_word_idx(f_idx),
        .ch_done(f_done), .mem_addr(f_maddr), .mem_enable(f_en), .mem_wr(f_wr),
        .mem_data_in(f_din), .mem_data_out(mem_dout), .mem_data_valid(f_dv));

    mem_arbiter_nch #(.NUM_CH(NC), .ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL),
                      .ADDR_STEP(STEP), .MEM_LAT(LAT), .ARB_MODE(1)) dut_rr (
        .clk(clk), .rst(rst), .ch_req(r_req), .ch_wr(wr), .ch_addr(addr), .ch_wdata(wdata),
        .ch_grant(r_grant), .ch_rvalid(r_rvalid), .ch_rdata(r_rdata), .ch_word_idx(r_idx),
        .ch_done(r_done), .mem_addr(r_maddr), .mem_enable(r_en), .mem_wr(r_wr),
        .mem_data_in(r_din), .mem_data_out(mem_dout), .mem_data_valid(r_dv));

    // Memory contents are a fixed function of the address.
    function automatic logic [15:0] mem_fn(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    // The memory answers a read LAT cycles after it sees mem_enable. The memory is not
    // reset, so reads in flight when rst asserts still return afterwards.
    logic [LAT-1:0] pv = '0;
    logic [DW-1:0]  pd [LAT];
    always @(posedge clk) begin
        pv[0] <= o_en && !o_wr;
        pd[0] <= mem_fn(o_maddr);
        for (int i = 1; i < LAT; i++) begin
            pv[i] <= pv[i-1];
            pd[i] <= pd[i-1];
        end
    end
    assign mem_dv   = pv[LAT-1];
    assign mem_dout = pd[LAT-1];

    int n_chk  = 0;
    int n_fail = 0;

    function automatic void chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, got, want, $time);
        end
    endfunction

    txn_t exp_q[$];
    txn_t plan[$];
    int   rr_ptr_m  = 0;
    int   drop_mode = 0;

    // Service-order model. Every pending channel holds its request until it is served.
    // Fixed priority therefore serves channels in ascending index order. Round-robin
    // serves the first pending channel at or after the pointer.
    task automatic model_order();
        txn_t pend[$];
        int   c;
        bit   hit;
        pend = plan;
        if (!act) begin
            for (int ch = 0; ch < NC; ch++)
                foreach (pend[j]) if (pend[j].ch == ch) exp_q.push_back(pend[j]);
        end else begin
            while (pend.size() > 0) begin
                hit = 0;
                for (int off = 0; off < NC && !hit; off++) begin
                    c = (rr_ptr_m + off) % NC;
                    for (int j = 0; j < pend.size() && !hit; j++) begin
                        if (pend[j].ch == c) begin
                            exp_q.push_back(pend[j]);
                            pend.delete(j);
                            rr_ptr_m = (c + 1) % NC;
                            hit = 1;
                        end
                    end
                end
            end
        end
    endtask

    function automatic int first_idx(input int c);
        foreach (plan[j]) if (plan[j].ch == c) return j;
        return -1;
    endfunction

    function automatic int count_ch(input int c);
        int n = 0;
        foreach (plan[j]) if (plan[j].ch == c) n++;
        return n;
    endfunction

    task automatic present(input int c);
        int j;
        j = first_idx(c);
        if (j < 0) begin
            req[c] = 1'b0;
        end else begin
            req[c]             = 1'b1;
            wr[c]              = plan[j].wr;
            addr[c*AW +: AW]   = plan[j].addr;
            wdata[c*DW +: DW]  = plan[j].wdata;
        end
    endtask

    task automatic add_txn(input int c, input bit w, input logic [15:0] a, input logic [15:0] d);
        txn_t t;
        t.ch = c; t.wr = w; t.addr = a; t.wdata = d;
        plan.push_back(t);
    endtask

    task automatic gen_plan(input int n);
        for (int i = 0; i < n; i++)
            add_txn($urandom_range(0, NC-1), ($urandom_range(0, 3) == 0),
                    16'($urandom), 16'($urandom));
    endtask

    // Drive every channel from the plan until all of its transactions have completed.
    task automatic run_batch();
        int cycles;
        int j;
        model_order();
        for (int c = 0; c < NC; c++) present(c);
        cycles = 0;
        while (plan.size() > 0 && cycles < 3000) begin
            @(negedge clk);
            cycles++;
            for (int c = 0; c < NC; c++) begin
                if (o_done[c]) begin
                    j = first_idx(c);
                    if (j >= 0) plan.delete(j);
                    present(c);
                end else if (o_grant[c] && req[c] && drop_mode != 0 && count_ch(c) == 1 &&
                             (drop_mode == 2 || $urandom_range(0, 1) == 1)) begin
                    req[c]            = 1'b0;
                    wr[c]             = 1'($urandom);
                    addr[c*AW +: AW]  = 16'($urandom);
                    wdata[c*DW +: DW] = 16'($urandom);
                end
            end
        end
        chk("batch_within_budget", 64'(cycles < 3000), 64'd1);
        plan.delete();
        req = '0;
        repeat (LAT + 4) @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    // Monitor: checks every cycle against the transaction currently at the head of the queue.
    bit            busy = 0;
    int            k    = 0;
    txn_t          cur;
    logic [15:0]   base, ea;
    logic [NC-1:0] oh;

    always @(posedge clk) begin
        #1;
        if (rst) begin
            busy = 0;
            chk("rst_grant",  64'(o_grant),  64'd0);
            chk("rst_rvalid", 64'(o_rvalid), 64'd0);
            chk("rst_done",   64'(o_done),   64'd0);
            chk("rst_mem",    64'({o_en, o_wr, o_maddr, o_din}), 64'd0);
            chk("rst_rdata",  64'({o_rdata, o_idx}), 64'd0);
        end else begin
            if (!busy && o_grant != '0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_grant", 64'(o_grant), 64'd0);
                end else begin
                    cur = exp_q.pop_front();
                    oh  = NC'(1) << cur.ch;
                    chk("grant_owner", 64'(o_grant), 64'(oh));
                    base = cur.wr ? cur.addr : cur.addr - (cur.addr % 16'(BL * STEP));
                    busy = 1;
                    k    = 0;
                end
            end
            if (busy) begin
                if (cur.wr) begin
                    if (k == 0) begin
                        chk("wr_cmd",    64'({o_en, o_wr}), 64'd3);
                        chk("wr_addr",   64'(o_maddr), 64'(base));
                        chk("wr_data",   64'(o_din),   64'(cur.wdata));
                        chk("wr_done",   64'(o_done),  64'(oh));
                        chk("wr_rvalid", 64'(o_rvalid), 64'd0);
                    end else begin
                        chk("wr_release", 64'({o_grant, o_en, o_done}), 64'd0);
                        busy = 0;
                    end
                end else begin
                    if (k < LAT + BL) chk("rd_grant_hold", 64'(o_grant), 64'(oh));
                    if (k < BL) begin
                        ea = base + 16'(k * STEP);
                        chk("rd_cmd",  64'({o_en, o_wr}), 64'd2);
                        chk("rd_addr", 64'(o_maddr), 64'(ea));
                    end else begin
                        chk("rd_cmd_off", 64'(o_en), 64'd0);
                    end
                    if (k >= LAT && k < LAT + BL) begin
                        ea = base + 16'((k - LAT) * STEP);
                        chk("rd_rvalid", 64'(o_rvalid), 64'(oh));
                        chk("rd_idx",    64'(o_idx),    64'(k - LAT));
                        chk("rd_data",   64'(o_rdata),  64'(mem_fn(ea)));
                    end else begin
                        chk("rd_rvalid_off", 64'(o_rvalid), 64'd0);
                    end
                    chk("rd_done", 64'(o_done), (k == LAT + BL - 1) ? 64'(oh) : 64'd0);
                    if (k == LAT + BL) begin
                        chk("rd_release", 64'(o_grant), 64'd0);
                        busy = 0;
                    end
                end
                k++;
            end else begin
                chk("idle_rvalid", 64'(o_rvalid), 64'd0);
                chk("idle_done",   64'(o_done),   64'd0);
                chk("idle_cmd",    64'(o_en),     64'd0);
            end
        end
    end

    // Reset during the third issue cycle of a ch0 line fill.
    task automatic reset_mid_burst();
        txn_t t;
        int   n;
        t.ch = 0; t.wr = 0; t.addr = 16'h0300; t.wdata = 16'h0;
        exp_q.push_back(t);
        req = '0;
        wr[0] = 1'b0;
        addr[0 +: AW] = 16'h0300;
        req[0] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!o_grant[0] && n < 20);
        chk("rst_test_granted", 64'(o_grant[0]), 64'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        rst = 1'b0;
        rr_ptr_m = 0;
        repeat (LAT + 4) @(negedge clk);
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        act   = 1'b0;
        req   = '0;
        wr    = '0;
        addr  = '0;
        wdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Fixed priority
        add_txn(0, 0, 16'h0014, 16'h0);
        run_batch();
        add_txn(0, 0, 16'h1000, 16'h0);
        add_txn(0, 0, 16'h2008, 16'h0);
        add_txn(0, 0, 16'h301F, 16'h0);
        add_txn(1, 0, 16'h4444, 16'h0);
        run_batch();
        add_txn(1, 1, 16'h0042, 16'hBEEF);
        run_batch();
        drop_mode = 2;
        add_txn(0, 0, 16'h1234, 16'h0);
        add_txn(2, 1, 16'hFFFF, 16'h1357);
        run_batch();
        drop_mode = 1;
        for (int b = 0; b < 4; b++) begin
            gen_plan(6);
            run_batch();
        end

        // Round-robin
        act = 1'b1;
        drop_mode = 0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            add_txn(0, 0, 16'(16'h0100 + i * 16), 16'h0);
            add_txn(1, 0, 16'(16'h0800 + i * 16), 16'h0);
        end
        run_batch();
        for (int i = 0; i < 2; i++) begin
            add_txn(0, 1, 16'(16'h0A00 + i), 16'(16'hA000 + i));
            add_txn(1, 0, 16'(16'h0B00 + i * 16), 16'h0);
            add_txn(2, 1, 16'(16'h0C00 + i), 16'(16'hC000 + i));
        end
        run_batch();
        reset_mid_burst();
        add_txn(2, 0, 16'hFFF6, 16'h0);
        add_txn(0, 1, 16'h0002, 16'h0D0D);
        run_batch();
        drop_mode = 1;
        for (int b = 0; b < 4; b++) begin
            gen_plan(6);
            run_batch();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
